// File: rtl/ula_video_timing.sv
// Video timing generator for the TK90X/TK95 ULA clone: pixel-clock prescale from the shared
// ULA counter, 448x312 beam counters, and registered sync/blank/display/INT/FLASH flags.
module ula_video_timing #(
  parameter int DIV_LOG2  = 1,
  parameter int H_TOTAL   = 448,
  parameter int V_TOTAL   = 312,
  parameter int H_SYNC_ST = 336,
  parameter int V_SYNC_ST = 248,
  parameter int INT_LEN   = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] cnt,
  output logic        pix_ce,
  output logic [8:0]  hc,
  output logic [8:0]  vc,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank,
  output logic        display,
  output logic        int_n,
  output logic        flash
);

  if (H_TOTAL > 512 || V_TOTAL > 512 || H_TOTAL < 2 || V_TOTAL < 2 || DIV_LOG2 < 0 || DIV_LOG2 > 12)
  begin : g_bad_params
    $error("ula_video_timing: H_TOTAL/V_TOTAL must be 2..512 and DIV_LOG2 0..12");
  end

  localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
  localparam logic [8:0] HS_FIRST   = 9'(H_SYNC_ST);
  localparam logic [8:0] HS_LAST    = 9'(H_SYNC_ST + 31);
  localparam logic [8:0] VS_FIRST   = 9'(V_SYNC_ST);
  localparam logic [8:0] VS_LAST    = 9'(V_SYNC_ST + 3);
  localparam logic [8:0] VB_LAST    = 9'(V_SYNC_ST + 7);
  localparam logic [8:0] INT_HC_END = 9'(INT_LEN);

  if (DIV_LOG2 == 0) begin : g_ce_every
    assign pix_ce = 1'b1;
  end else begin : g_ce_div
    assign pix_ce = (cnt[DIV_LOG2-1:0] == '0);
  end

  // Only the low DIV_LOG2 bits of the shared counter matter here.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

  logic [8:0] hc_q, hc_d, vc_q, vc_d, hc_nxt, vc_nxt;
  logic [4:0] frame_cnt_q, frame_cnt_d, frame_cnt_nxt;
  logic       hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
  logic       blank_q, blank_d, display_q, display_d, int_n_q, int_n_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    hc_nxt        = hc_q + 9'd1;
    vc_nxt        = vc_q;
    frame_cnt_nxt = frame_cnt_q;
    if (hc_q == H_LAST) begin
      hc_nxt = '0;
      if (vc_q == V_LAST) begin
        vc_nxt        = '0;
        frame_cnt_nxt = frame_cnt_q + 5'd1;
      end else begin
        vc_nxt = vc_q + 9'd1;
      end
    end

    hc_d        = hc_q;
    vc_d        = vc_q;
    frame_cnt_d = frame_cnt_q;
    hsync_n_d   = hsync_n_q;
    vsync_n_d   = vsync_n_q;
    blank_d     = blank_q;
    display_d   = display_q;
    int_n_d     = int_n_q;

    // Flags decode the post-increment counts so they line up with the hc/vc presented next cycle.
    if (pix_ce) begin
      hc_d        = hc_nxt;
      vc_d        = vc_nxt;
      frame_cnt_d = frame_cnt_nxt;
      hsync_n_d   = !((hc_nxt >= HS_FIRST) && (hc_nxt <= HS_LAST));
      vsync_n_d   = !((vc_nxt >= VS_FIRST) && (vc_nxt <= VS_LAST));
      blank_d     = ((hc_nxt >= 9'd320) && (hc_nxt <= 9'd415)) ||
                    ((vc_nxt >= VS_FIRST) && (vc_nxt <= VB_LAST));
      display_d   = (hc_nxt < 9'd256) && (vc_nxt < 9'd192);
      int_n_d     = !((vc_nxt == VS_FIRST) && (hc_nxt < INT_HC_END));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hc_q        <= '0;
      vc_q        <= '0;
      frame_cnt_q <= '0;
      hsync_n_q   <= 1'b1;
      vsync_n_q   <= 1'b1;
      blank_q     <= 1'b0;
      display_q   <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      frame_cnt_q <= frame_cnt_d;
      hsync_n_q   <= hsync_n_d;
      vsync_n_q   <= vsync_n_d;
      blank_q     <= blank_d;
      display_q   <= display_d;
      int_n_q     <= int_n_d;
    end
  end

  assign hc      = hc_q;
  assign vc      = vc_q;
  assign hsync_n = hsync_n_q;
  assign vsync_n = vsync_n_q;
  assign blank   = blank_q;
  assign display = display_q;
  assign int_n   = int_n_q;
  assign flash   = frame_cnt_q[4];

endmodule

// File: tb/tb_ula_video_timing.sv
// Self-checking bench for ula_video_timing: three parameterisations (48K default, divide-by-1
// short frame, divide-by-4 tiny frame) checked every clock against an arithmetic beam model.
module tb_ula_video_timing;

  logic        clock;
  logic        reset;
  logic [11:0] cnt;

  logic        pce   [3];
  logic [8:0]  hcv   [3];
  logic [8:0]  vcv   [3];
  logic        hs    [3];
  logic        vs    [3];
  logic        bl    [3];
  logic        dp    [3];
  logic        irq_n [3];
  logic        fl    [3];

  int     n_checks = 0;
  int     n_errors = 0;
  longint t   [3];
  bit     adv [3];

  ula_video_timing u_def (
    .clock(clock), .reset(reset), .cnt(cnt), .pix_ce(pce[0]), .hc(hcv[0]), .vc(vcv[0]),
    .hsync_n(hs[0]), .vsync_n(vs[0]), .blank(bl[0]), .display(dp[0]), .int_n(irq_n[0]), .flash(fl[0])
  );

  ula_video_timing #(.DIV_LOG2(0), .H_TOTAL(448), .V_TOTAL(10), .H_SYNC_ST(336), .V_SYNC_ST(4),
                     .INT_LEN(64)) u_mid (
    .clock(clock), .reset(reset), .cnt(cnt), .pix_ce(pce[1]), .hc(hcv[1]), .vc(vcv[1]),
    .hsync_n(hs[1]), .vsync_n(vs[1]), .blank(bl[1]), .display(dp[1]), .int_n(irq_n[1]), .flash(fl[1])
  );

  ula_video_timing #(.DIV_LOG2(2), .H_TOTAL(16), .V_TOTAL(8), .H_SYNC_ST(4), .V_SYNC_ST(2),
                     .INT_LEN(3)) u_tiny (
    .clock(clock), .reset(reset), .cnt(cnt), .pix_ce(pce[2]), .hc(hcv[2]), .vc(vcv[2]),
    .hsync_n(hs[2]), .vsync_n(vs[2]), .blank(bl[2]), .display(dp[2]), .int_n(irq_n[2]), .flash(fl[2])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Free-running ULA counter, random starting phase, advancing on the falling edge.
  initial begin
    cnt = 12'($urandom);
    forever begin
      @(negedge clock);
      cnt = cnt + 12'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 2;
  endfunction

  function automatic logic ce_of(int i, logic [11:0] c);
    int d = div_of(i);
    return (d == 0) ? 1'b1 : ((int'(c) % (1 << d)) == 0);
  endfunction

  // Beam position follows directly from the number of pixel clocks since reset.
  function automatic logic [24:0] expect_vec(int i, longint tt, logic [11:0] c);
    longint ht, vt, hss, vss, il, h, v, line, fr;
    logic   ce, hsn, vsn, blk, dsp, irn, fls;
    case (i)
      0:       begin ht = 448; vt = 312; hss = 336; vss = 248; il = 64; end
      1:       begin ht = 448; vt = 10;  hss = 336; vss = 4;   il = 64; end
      default: begin ht = 16;  vt = 8;   hss = 4;   vss = 2;   il = 3;  end
    endcase
    ce = ce_of(i, c);
    if (tt == 0) return {ce, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    h    = tt % ht;
    line = tt / ht;
    v    = line % vt;
    fr   = (line / vt) % 32;
    hsn  = !(h >= hss && h <= hss + 31);
    vsn  = !(v >= vss && v <= vss + 3);
    blk  = (h >= 320 && h <= 415) || (v >= vss && v <= vss + 7);
    dsp  = (h < 256) && (v < 192);
    irn  = !(v == vss && h < il);
    fls  = (fr >= 16);
    return {ce, 9'(h), 9'(v), hsn, vsn, blk, dsp, irn, fls};
  endfunction

  function automatic logic [24:0] obs_vec(int i);
    return {pce[i], hcv[i], vcv[i], hs[i], vs[i], bl[i], dp[i], irq_n[i], fl[i]};
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_u%0d", tag, i), 32'(obs_vec(i)), 32'(expect_vec(i, t[i], cnt)));
  endtask

  task automatic cycle();
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      adv[i] = !reset && ce_of(i, cnt);
      if (adv[i]) t[i]++;
    end
    #1;
    check_all("vec");
  endtask

  // Called at posedge+1: asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) t[i] = 0;
    #1;
    check_all(tag);
    repeat (2 + $urandom_range(0, 3)) cycle();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int hs_low, hs_falls, int_low;
    logic hs_prev;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) t[i] = 0;
    #2;
    check_all("reset_t0");
    repeat (3) cycle();
    @(negedge clock);
    reset = 1'b0;

    hs_low = 0; hs_falls = 0; int_low = 0; hs_prev = 1'b1;
    for (int k = 0; k < 16384; k++) begin
      cycle();
      if (k < 896) begin
        if (adv[0] && !hs[0]) hs_low++;
        if (hs_prev && !hs[0]) hs_falls++;
        hs_prev = hs[0];
      end
      if (k < 4480 && adv[1] && !irq_n[1]) int_low++;
      if (k == 895) begin
        chk("def_hc_after_2x448", 32'(hcv[0]), 32'd0);
        chk("def_vc_after_2x448", 32'(vcv[0]), 32'd1);
        chk("def_hsync_low_pix", 32'(hs_low), 32'd32);
        chk("def_hsync_pulses", 32'(hs_falls), 32'd1);
      end
      if (k == 4479) begin
        chk("mid_frame_wrap_hc", 32'(hcv[1]), 32'd0);
        chk("mid_frame_wrap_vc", 32'(vcv[1]), 32'd0);
        chk("mid_int_low_pix", 32'(int_low), 32'd64);
      end
      if (k == 8191) chk("tiny_flash_16", 32'(fl[2]), 32'd1);
      if (k == 16383) begin
        chk("tiny_flash_32", 32'(fl[2]), 32'd0);
        chk("tiny_hc_vc_wrap", 32'({hcv[2], vcv[2]}), 32'd0);
      end
    end

    repeat ($urandom_range(1, 3000)) cycle();
    async_reset("rst_random");
    repeat ($urandom_range(200, 2500)) cycle();

    for (int k = 0; k < 6000 && irq_n[1] !== 1'b0; k++) cycle();
    chk("mid_int_reached", 32'(irq_n[1]), 32'd0);
    repeat ($urandom_range(0, 40)) cycle();
    async_reset("rst_during_int");
    for (int k = 0; k < 6000; k++) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
